temp_stats_logger: RTL
======================

Name: temp_stats_logger

Overview:
- Downstream consumer of the Fahrenheit temperature byte produced by the sensor/converter path.
- Samples the temperature on a fixed period and logs it into the BRAM_TemperatureValues single-port BRAM as a circular history window.
- After each logged sample, rescans the valid window and publishes average, maximum and minimum temperature to the display-selection logic.

Parameters:
SAMPLE_PERIOD, 100_000_000, clock cycles between samples (1 s at 100 MHz); must be >= 2
ADDR_W, 8, BRAM address width
DEPTH, 256, window length in entries; must equal 2**ADDR_W

Ports:
CLK100MHZ  input  1  system clock, 100 MHz
CPU_RESETN  input  1  reset, asynchronous, active-low
f_data  input  8  current temperature, deg F, unsigned
log_en  input  1  1 = sampling enabled
bram_we  output  1  BRAM write enable
bram_addr  output  ADDR_W  BRAM address
bram_din  output  8  BRAM write data
bram_dout  input  8  BRAM read data; valid 1 cycle after address is presented
ave_temp  output  8  floor average of valid window
max_temp  output  8  maximum of valid window
min_temp  output  8  minimum of valid window
sample_count  output  ADDR_W+1  valid entries, saturates at DEPTH
stats_valid  output  1  one-cycle pulse when stats update
busy  output  1  1 while FSM is not in IDLE

Behaviour:
- Reset (async, CPU_RESETN=0):
  - All outputs 0; FSM to IDLE.
  - Internal state cleared: timer=0, wr_ptr=0, count=0, pending=0.
  - BRAM contents are not cleared; they are ignored because count=0.
- Input synchroniser: f_data is double-registered before use. The sampled value is the synchronised value in the tick cycle.
- Timer:
  - Counts 0..SAMPLE_PERIOD-1 while log_en=1; held at 0 while log_en=0.
  - tick asserts for one cycle when timer=SAMPLE_PERIOD-1, then the timer wraps to 0.
- Pending tick:
  - A tick while busy=1 sets pending.
  - A second tick while pending=1 is dropped.
  - IDLE consumes pending before a new tick.
  - Dropping log_en does not cancel a pending sample or an operation already in progress.
- FSM:
  - IDLE: on tick or pending, latch sample and go to WRITE; clear pending.
  - WRITE (1 cycle): bram_we=1, bram_addr=wr_ptr, bram_din=sample. wr_ptr increments modulo DEPTH; count increments, saturating at DEPTH. Next state: SCAN.
  - SCAN: presents addr 0..count-1, one per cycle. Each bram_dout is accumulated one cycle later into sum (8+ADDR_W bits, no overflow possible), run_max and run_min (init 0 and 255). Lasts count+1 cycles; bram_we=0 throughout. Next state: DIV.
  - DIV: restoring divide of sum by count, 8+ADDR_W iterations, one bit per cycle. Quotient is floor; the low 8 bits are guaranteed sufficient. Next state: UPDATE.
  - UPDATE (1 cycle): register ave_temp, max_temp, min_temp and sample_count; pulse stats_valid. Next state: IDLE.
- Window: once count=DEPTH, the WRITE overwrites the oldest entry at wr_ptr. The scan covers all DEPTH entries, so the window is the last DEPTH samples.
- Outputs hold their values between updates and never show partial results.
- Latency: stats_valid occurs exactly count_new+ADDR_W+11 cycles after the tick cycle, where count_new = count after the WRITE. Breakdown: 1 IDLE, 1 WRITE, count_new+1 SCAN, 8+ADDR_W DIV, 1 UPDATE.
- bram_addr is 0 and bram_din is 0 whenever not in WRITE or SCAN.
- Reset mid-operation: takes effect immediately in any state; bram_we deasserts asynchronously. The next sample writes addr 0.

Test Plan:
Bench parameters for all scenarios: SAMPLE_PERIOD=100, ADDR_W=3, DEPTH=8.
1. Reset: hold CPU_RESETN=0, f_data=72, log_en=1 -> all outputs 0, no bram_we. Release -> first bram_we at cycle 100 + sync delay, addr 0, din 72.
2. Constant input: f_data=72, three ticks -> writes to addr 0,1,2 with data 72. After the third stats_valid: count=3, ave=max=min=72.
3. Varying input: samples 70,75,80,65 -> after the fourth stats_valid: ave=72 (290/4 floored), max=80, min=65, count=4. Latency = 4+3+11 = 18 cycles after tick.
4. Wrap-around: samples 60..69 (10 samples) -> 9th sample written to addr 0, 10th to addr 1. Final count=8, min=62, max=69, ave=65 (524/8 floored).
5. Enable gating: log_en=0 for 500 cycles after 2 samples -> no bram_we, stats and count unchanged, busy=0. Re-enable -> next write occurs 100 cycles later at addr 2.
6. Reset mid-SCAN: assert CPU_RESETN=0 during SCAN with count=5 -> outputs 0 immediately, bram_we=0. After release, sample 50 -> write addr 0; stats ave=max=min=50, count=1.

Source files
------------

// File: rtl/temp_stats_logger_if.sv
// BRAM port bundle between temp_stats_logger (master) and the
// single-port temperature history BRAM (slave).
// Signals: bram_we, bram_addr, bram_din (to BRAM), bram_dout (from BRAM,
// valid one cycle after the address is presented).
interface temp_stats_logger_if #(
    parameter int ADDR_W = 8
);
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [7:0]        bram_din;
    logic [7:0]        bram_dout;

    modport master (
        output bram_we,
        output bram_addr,
        output bram_din,
        input  bram_dout
    );

    modport slave (
        input  bram_we,
        input  bram_addr,
        input  bram_din,
        output bram_dout
    );
endinterface

// File: rtl/temp_stats_logger.sv
// Periodic temperature logger: writes a circular history into BRAM, then
// rescans it and publishes floor-average, max and min of the window.
// Ports: CLK100MHZ/CPU_RESETN clock and async active-low reset; f_data,
// log_en inputs; bram (master modport); ave_temp, max_temp, min_temp,
// sample_count, stats_valid, busy status outputs.
module temp_stats_logger #(
    parameter int SAMPLE_PERIOD = 100_000_000,
    parameter int ADDR_W        = 8,
    parameter int DEPTH         = 256
) (
    input  logic                CLK100MHZ,
    input  logic                CPU_RESETN,
    input  logic [7:0]          f_data,
    input  logic                log_en,
    temp_stats_logger_if.master bram,
    output logic [7:0]          ave_temp,
    output logic [7:0]          max_temp,
    output logic [7:0]          min_temp,
    output logic [ADDR_W:0]     sample_count,
    output logic                stats_valid,
    output logic                busy
);
    localparam int TW = $clog2(SAMPLE_PERIOD);
    localparam int SW = 8 + ADDR_W;
    localparam int CW = $clog2(SW);

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_SCAN, S_DIV, S_UPDATE
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        sync1_q, sync1_d, sync2_q, sync2_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              pend_q, pend_d;
    logic [7:0]        sample_q, sample_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [SW-1:0]     sum_q, sum_d;
    logic [7:0]        rmax_q, rmax_d, rmin_q, rmin_d;
    logic [ADDR_W+1:0] rem_q, rem_d;
    logic [SW-1:0]     div_q, div_d;
    logic [CW-1:0]     dcnt_q, dcnt_d;
    logic [7:0]        ave_q, ave_d, maxo_q, maxo_d;
    logic [7:0]        mino_q, mino_d;
    logic [ADDR_W:0]   cnto_q, cnto_d;

    logic              tick;
    logic [ADDR_W+1:0] rem_sh, cnt_ext, rem_n;
    logic [SW-1:0]     div_n;
    logic              ge;

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q  <= S_IDLE;
            sync1_q  <= '0;
            sync2_q  <= '0;
            timer_q  <= '0;
            pend_q   <= 1'b0;
            sample_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            idx_q    <= '0;
            sum_q    <= '0;
            rmax_q   <= '0;
            rmin_q   <= '0;
            rem_q    <= '0;
            div_q    <= '0;
            dcnt_q   <= '0;
            ave_q    <= '0;
            maxo_q   <= '0;
            mino_q   <= '0;
            cnto_q   <= '0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            timer_q  <= timer_d;
            pend_q   <= pend_d;
            sample_q <= sample_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            sum_q    <= sum_d;
            rmax_q   <= rmax_d;
            rmin_q   <= rmin_d;
            rem_q    <= rem_d;
            div_q    <= div_d;
            dcnt_q   <= dcnt_d;
            ave_q    <= ave_d;
            maxo_q   <= maxo_d;
            mino_q   <= mino_d;
            cnto_q   <= cnto_d;
        end
    end

    // One restoring-division step: shift in the next dividend bit,
    // subtract the divisor when it fits, shift the quotient bit in.
    always_comb begin
        rem_sh  = (rem_q << 1) | (ADDR_W+2)'(div_q[SW-1]);
        cnt_ext = {1'b0, count_q};
        ge      = (rem_sh >= cnt_ext);
        rem_n   = ge ? (rem_sh - cnt_ext) : rem_sh;
        div_n   = {div_q[SW-2:0], ge};
    end

    always_comb begin
        state_d  = state_q;
        sync1_d  = f_data;
        sync2_d  = sync1_q;
        pend_d   = pend_q;
        sample_d = sample_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        idx_d    = idx_q;
        sum_d    = sum_q;
        rmax_d   = rmax_q;
        rmin_d   = rmin_q;
        rem_d    = rem_q;
        div_d    = div_q;
        dcnt_d   = dcnt_q;
        ave_d    = ave_q;
        maxo_d   = maxo_q;
        mino_d   = mino_q;
        cnto_d   = cnto_q;
        bram.bram_we   = 1'b0;
        bram.bram_addr = '0;
        bram.bram_din  = '0;

        tick    = log_en && (timer_q == TW'(SAMPLE_PERIOD - 1));
        timer_d = (!log_en || tick) ? '0 : timer_q + 1'b1;

        if (tick && state_q != S_IDLE)
            pend_d = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (tick || pend_q) begin
                    sample_d = sync2_q;
                    // A tick coinciding with a consumed pending
                    // request is kept as the next pending one.
                    pend_d   = pend_q && tick;
                    state_d  = S_WRITE;
                end
            end
            S_WRITE: begin
                bram.bram_we   = 1'b1;
                bram.bram_addr = wr_ptr_q;
                bram.bram_din  = sample_q;
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (count_q != (ADDR_W+1)'(DEPTH))
                    count_d = count_q + 1'b1;
                idx_d   = '0;
                sum_d   = '0;
                rmax_d  = 8'h00;
                rmin_d  = 8'hFF;
                state_d = S_SCAN;
            end
            S_SCAN: begin
                // Address leads data by one cycle; idx 0 only
                // issues a read, idx == count only accumulates.
                if (idx_q < count_q)
                    bram.bram_addr = idx_q[ADDR_W-1:0];
                if (idx_q != '0) begin
                    sum_d = sum_q + SW'(bram.bram_dout);
                    if (bram.bram_dout > rmax_q)
                        rmax_d = bram.bram_dout;
                    if (bram.bram_dout < rmin_q)
                        rmin_d = bram.bram_dout;
                end
                idx_d = idx_q + 1'b1;
                if (idx_q == count_q) begin
                    div_d   = sum_d;
                    rem_d   = '0;
                    dcnt_d  = '0;
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                rem_d  = rem_n;
                div_d  = div_n;
                dcnt_d = dcnt_q + 1'b1;
                if (dcnt_q == CW'(SW - 1)) begin
                    // Results land together with the pulse.
                    ave_d   = div_n[7:0];
                    maxo_d  = rmax_q;
                    mino_d  = rmin_q;
                    cnto_d  = count_q;
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign ave_temp     = ave_q;
    assign max_temp     = maxo_q;
    assign min_temp     = mino_q;
    assign sample_count = cnto_q;
    assign stats_valid  = (state_q == S_UPDATE);
    assign busy         = (state_q != S_IDLE);
endmodule
